// File: rtl/tlv5618_rx.sv
// ============================================================================
// Module      : tlv5618_rx
// Description : TLV5618-style 3-wire serial receiver. Decodes 16-bit words
//               into DAC A/B codes, a double-buffer latch and SPD/PWR bits.
//               Optional macro TLV5618_RX_ERR_CNT_EN adds a saturating
//               8-bit frame-error counter output (err_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlv5618_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DAC_CS_N,
    input  logic        DAC_SCLK,
    input  logic        DAC_DIN,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [11:0] dac_buf,
    output logic        speed,
    output logic        pwr_down,
    output logic        word_valid,
    output logic        frame_err
`ifdef TLV5618_RX_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_t;

    localparam logic [4:0] c_WORD_BITS = 5'd16;
    localparam logic [4:0] c_CNT_MAX   = 5'd17;

    state_t                   r_state;
    state_t                   w_next;
    logic [SYNC_STAGES-1:0]   r_cs_sync;
    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_din_sync;
    logic                     r_cs_prev;
    logic                     r_sclk_prev;
    logic                     r_pend;
    logic [15:0]              r_shift;
    logic [4:0]               r_cnt;

    logic                     w_cs;
    logic                     w_sclk;
    logic                     w_din;
    logic                     w_cs_fall;
    logic                     w_cs_rise;
    logic                     w_sclk_fall;
    logic [1:0]               w_cmd;
    logic                     w_good_len;
    logic                     w_valid_set;
    logic                     w_err_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_din_sync  <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], DAC_CS_N};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], DAC_SCLK};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], DAC_DIN};
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_din       = r_din_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk;

    // Command is {R1, R0}; the reserved code 2'b11 is rejected like a bad length.
    assign w_cmd       = {r_shift[15], r_shift[12]};
    assign w_good_len  = (r_cnt == c_WORD_BITS);
    assign w_valid_set = (r_state == DECODE) && w_good_len && (w_cmd != 2'b11);
    assign w_err_set   = (r_state == DECODE) && (!w_good_len || (w_cmd == 2'b11));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall || r_pend) w_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_next = DECODE;
            DECODE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            dac_a      <= '0;
            dac_b      <= '0;
            dac_buf    <= '0;
            speed      <= 1'b0;
            pwr_down   <= 1'b0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= w_valid_set;
            frame_err  <= w_err_set;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall || r_pend) begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_sclk_fall) begin
                        r_shift <= {r_shift[14:0], w_din};
                        if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 5'd1;
                    end
                end
                DECODE: begin
                    // A new frame may start while we decode; remember it for IDLE.
                    if (w_cs_fall) r_pend <= 1'b1;
                    if (w_good_len) begin
                        speed    <= r_shift[14];
                        pwr_down <= r_shift[13];
                        case (w_cmd)
                            2'b00: begin
                                dac_b   <= r_shift[11:0];
                                dac_buf <= r_shift[11:0];
                            end
                            2'b01: dac_buf <= r_shift[11:0];
                            2'b10: begin
                                dac_a <= r_shift[11:0];
                                dac_b <= dac_buf;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TLV5618_RX_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (w_err_set && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlv5618_rx.sv
// ============================================================================
// Module      : tb_tlv5618_rx
// Description : Directed self-checking bench for tlv5618_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlv5618_rx;

    localparam int c_SYNC  = 2;
    localparam int c_HALF  = 6;
    localparam int c_SETTLE = 10;

    logic        clk;
    logic        rst;
    logic        cs_n;
    logic        sclk;
    logic        din;
    logic [11:0] dac_a;
    logic [11:0] dac_b;
    logic [11:0] dac_buf;
    logic        speed;
    logic        pwr_down;
    logic        word_valid;
    logic        frame_err;
`ifdef TLV5618_RX_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int wv_total = 0;
    int fe_total = 0;
    int both_total = 0;
    int wv_snap;
    int fe_snap;

    tlv5618_rx #(.SYNC_STAGES(c_SYNC)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .DAC_CS_N   (cs_n),
        .DAC_SCLK   (sclk),
        .DAC_DIN    (din),
        .dac_a      (dac_a),
        .dac_b      (dac_b),
        .dac_buf    (dac_buf),
        .speed      (speed),
        .pwr_down   (pwr_down),
        .word_valid (word_valid),
        .frame_err  (frame_err)
`ifdef TLV5618_RX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid) wv_total++;
            if (frame_err) fe_total++;
            if (word_valid && frame_err) both_total++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        wait_clk(c_HALF);
    endtask

    task automatic send_bit(input logic b);
        din  = b;
        sclk = 1'b1;
        wait_clk(c_HALF);
        sclk = 1'b0;
        wait_clk(c_HALF);
    endtask

    task automatic frame_end(input int gap);
        cs_n = 1'b1;
        wait_clk(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits, input int gap);
        wv_snap = wv_total;
        fe_snap = fe_total;
        frame_start();
        for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
        frame_end(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; din = 1'b0;
        wait_clk(4);
        n_checks++; if (dac_a !== 12'h000) $display("FAIL reset dac_a: got %h want %h", dac_a, 12'h000); else n_pass++;
        n_checks++; if (dac_b !== 12'h000) $display("FAIL reset dac_b: got %h want %h", dac_b, 12'h000); else n_pass++;
        n_checks++; if (dac_buf !== 12'h000) $display("FAIL reset dac_buf: got %h want %h", dac_buf, 12'h000); else n_pass++;
        n_checks++; if ({speed, pwr_down} !== 2'b00) $display("FAIL reset spd_pwr: got %b want 00", {speed, pwr_down}); else n_pass++;
        n_checks++; if ({word_valid, frame_err} !== 2'b00) $display("FAIL reset pulses: got %b want 00", {word_valid, frame_err}); else n_pass++;
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_write_a();
        send_word(32'hC7FF, 16, c_SETTLE);
        n_checks++; if (dac_a !== 12'h7FF) $display("FAIL write_a dac_a: got %h want %h", dac_a, 12'h7FF); else n_pass++;
        n_checks++; if (dac_b !== 12'h000) $display("FAIL write_a dac_b: got %h want %h", dac_b, 12'h000); else n_pass++;
        n_checks++; if (speed !== 1'b1) $display("FAIL write_a speed: got %b want 1", speed); else n_pass++;
        n_checks++; if (pwr_down !== 1'b0) $display("FAIL write_a pwr_down: got %b want 0", pwr_down); else n_pass++;
        n_checks++; if (wv_total - wv_snap != 1) $display("FAIL write_a word_valid: got %0d pulses want 1", wv_total - wv_snap); else n_pass++;
        n_checks++; if (fe_total - fe_snap != 0) $display("FAIL write_a frame_err: got %0d pulses want 0", fe_total - fe_snap); else n_pass++;
    endtask

    task automatic test_double_buffer();
        send_word(32'h1123, 16, c_SETTLE);
        n_checks++; if (dac_buf !== 12'h123) $display("FAIL dbuf1 dac_buf: got %h want %h", dac_buf, 12'h123); else n_pass++;
        n_checks++; if (dac_b !== 12'h000) $display("FAIL dbuf1 dac_b: got %h want %h", dac_b, 12'h000); else n_pass++;
        n_checks++; if (dac_a !== 12'h7FF) $display("FAIL dbuf1 dac_a: got %h want %h", dac_a, 12'h7FF); else n_pass++;
        n_checks++; if (speed !== 1'b0) $display("FAIL dbuf1 speed: got %b want 0", speed); else n_pass++;
        send_word(32'h8456, 16, c_SETTLE);
        n_checks++; if (dac_a !== 12'h456) $display("FAIL dbuf2 dac_a: got %h want %h", dac_a, 12'h456); else n_pass++;
        n_checks++; if (dac_b !== 12'h123) $display("FAIL dbuf2 dac_b: got %h want %h", dac_b, 12'h123); else n_pass++;
        n_checks++; if (wv_total - wv_snap != 1) $display("FAIL dbuf2 word_valid: got %0d pulses want 1", wv_total - wv_snap); else n_pass++;
    endtask

    task automatic test_short_frame();
        send_word(32'h0ABC, 15, c_SETTLE);
        n_checks++; if (fe_total - fe_snap != 1) $display("FAIL short frame_err: got %0d pulses want 1", fe_total - fe_snap); else n_pass++;
        n_checks++; if (wv_total - wv_snap != 0) $display("FAIL short word_valid: got %0d pulses want 0", wv_total - wv_snap); else n_pass++;
        n_checks++; if ({dac_a, dac_b, dac_buf} !== {12'h456, 12'h123, 12'h123}) $display("FAIL short regs: got %h %h %h want 456 123 123", dac_a, dac_b, dac_buf); else n_pass++;
        n_checks++; if ({speed, pwr_down} !== 2'b00) $display("FAIL short spd_pwr: got %b want 00", {speed, pwr_down}); else n_pass++;
`ifdef TLV5618_RX_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL short err_cnt: got %0d want 1", err_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reserved();
        send_word(32'h9ABC, 16, c_SETTLE);
        n_checks++; if (fe_total - fe_snap != 1) $display("FAIL reserved frame_err: got %0d pulses want 1", fe_total - fe_snap); else n_pass++;
        n_checks++; if (wv_total - wv_snap != 0) $display("FAIL reserved word_valid: got %0d pulses want 0", wv_total - wv_snap); else n_pass++;
        n_checks++; if ({dac_a, dac_b, dac_buf} !== {12'h456, 12'h123, 12'h123}) $display("FAIL reserved regs: got %h %h %h want 456 123 123", dac_a, dac_b, dac_buf); else n_pass++;
    endtask

    task automatic test_long_frame();
        send_word(32'h16ABC, 17, c_SETTLE);
        n_checks++; if (fe_total - fe_snap != 1) $display("FAIL long frame_err: got %0d pulses want 1", fe_total - fe_snap); else n_pass++;
        n_checks++; if ({dac_a, dac_b, dac_buf} !== {12'h456, 12'h123, 12'h123}) $display("FAIL long regs: got %h %h %h want 456 123 123", dac_a, dac_b, dac_buf); else n_pass++;
`ifdef TLV5618_RX_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd3) $display("FAIL long err_cnt: got %0d want 3", err_cnt); else n_pass++;
`endif
    endtask

    task automatic test_write_b();
        send_word(32'h6ABC, 16, c_SETTLE);
        n_checks++; if (dac_b !== 12'hABC) $display("FAIL write_b dac_b: got %h want %h", dac_b, 12'hABC); else n_pass++;
        n_checks++; if (dac_buf !== 12'hABC) $display("FAIL write_b dac_buf: got %h want %h", dac_buf, 12'hABC); else n_pass++;
        n_checks++; if (dac_a !== 12'h456) $display("FAIL write_b dac_a: got %h want %h", dac_a, 12'h456); else n_pass++;
        n_checks++; if ({speed, pwr_down} !== 2'b11) $display("FAIL write_b spd_pwr: got %b want 11", {speed, pwr_down}); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w;
        w = 16'h0FFF;
        frame_start();
        for (int i = 15; i >= 8; i--) send_bit(w[i]);
        rst = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        wait_clk(3);
        n_checks++; if (dac_b !== 12'h000) $display("FAIL midrst dac_b_in_reset: got %h want %h", dac_b, 12'h000); else n_pass++;
        rst = 1'b0;
        wait_clk(6);
        send_word(32'h0055, 16, c_SETTLE);
        n_checks++; if (dac_b !== 12'h055) $display("FAIL midrst dac_b: got %h want %h", dac_b, 12'h055); else n_pass++;
        n_checks++; if (dac_a !== 12'h000) $display("FAIL midrst dac_a: got %h want %h", dac_a, 12'h000); else n_pass++;
        n_checks++; if (fe_total - fe_snap != 0) $display("FAIL midrst frame_err: got %0d pulses want 0", fe_total - fe_snap); else n_pass++;
        n_checks++; if (wv_total - wv_snap != 1) $display("FAIL midrst word_valid: got %0d pulses want 1", wv_total - wv_snap); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int wv0;
        wv0 = wv_total;
        send_word(32'h0001, 16, c_SYNC + 2);
        send_word(32'h0002, 16, c_SETTLE);
        n_checks++; if (wv_total - wv0 != 2) $display("FAIL b2b word_valid: got %0d pulses want 2", wv_total - wv0); else n_pass++;
        n_checks++; if (dac_b !== 12'h002) $display("FAIL b2b dac_b: got %h want %h", dac_b, 12'h002); else n_pass++;
        n_checks++; if (dac_buf !== 12'h002) $display("FAIL b2b dac_buf: got %h want %h", dac_buf, 12'h002); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_double_buffer();
        test_short_frame();
        test_reserved();
        test_long_frame();
        test_write_b();
        test_reset_mid_frame();
        test_back_to_back();
        n_checks++; if (both_total != 0) $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_total); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
